uart_rx_demux: RTL and testbench

- Receive-side counterpart of the mouse-data UART link.
- Pops bytes from the UART RX FIFO one at a time.
- Routes bytes alternately to a right-byte register and a left-byte register: first byte → right (slot 0), second → left (slot 1).
- Runs a watchdog that resynchronises the slot pointer when a pair is left half-received.
- Sits between the uart RX FIFO and the game logic that consumes the remote mouse state.

---
 rtl/uart_rx_demux_if.sv | 34 +++
 rtl/uart_rx_demux.sv | 119 +++++++++++
 tb/tb_uart_rx_demux.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_demux_if.sv
// Signal bundle for the RX demux: FIFO pop side and mouse-state consumer side.
// The demux drives through master; the FIFO and game logic sit on slave.
interface uart_rx_demux_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic [7:0] data_second_mouse_right;
  logic [7:0] data_second_mouse_left;
  logic       right_valid;
  logic       left_valid;
  logic       resync;

  modport master (
    input  rx_empty,
    input  r_data,
    output rd_uart,
    output data_second_mouse_right,
    output data_second_mouse_left,
    output right_valid,
    output left_valid,
    output resync
  );

  modport slave (
    output rx_empty,
    output r_data,
    input  rd_uart,
    input  data_second_mouse_right,
    input  data_second_mouse_left,
    input  right_valid,
    input  left_valid,
    input  resync
  );
endinterface

// File: rtl/uart_rx_demux.sv
// Pops UART RX bytes and routes them alternately to right/left mouse registers,
// with an idle watchdog that resyncs the slot. UART_RX_PAIR_COMMIT_EN: commit pairs atomically.
module uart_rx_demux #(
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_demux_if.master  bus
);

  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             slot;
  logic [CNT_W-1:0] wd_cnt;
  logic [7:0]       shadow;
  logic             capture;
  logic             commit;
  logic             expire;
  logic             wd_run;
`ifdef UART_RX_PAIR_COMMIT_EN
  logic [7:0]       pending;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-cycle actions; a capture beats watchdog expiry.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    commit    = 1'b0;
    expire    = 1'b0;
    wd_run    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.rx_empty) begin
          capture   = 1'b1;
          state_nxt = POP;
        end else if (slot) begin
          if (wd_cnt == WD_LAST) expire = 1'b1;
          else                   wd_run = 1'b1;
        end
      end
      POP: begin
        commit    = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, slot pointer and watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      slot   <= 1'b0;
      wd_cnt <= '0;
    end else begin
      if (capture) shadow <= bus.r_data;
      if (expire)      slot <= 1'b0;
      else if (commit) slot <= ~slot;
      if (capture || expire || !slot) wd_cnt <= '0;
      else if (wd_run)                wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Registered pop strobe, resync strobe and committed output bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_uart                 <= 1'b0;
      bus.resync                  <= 1'b0;
      bus.right_valid             <= 1'b0;
      bus.left_valid              <= 1'b0;
      bus.data_second_mouse_right <= '0;
      bus.data_second_mouse_left  <= '0;
`ifdef UART_RX_PAIR_COMMIT_EN
      pending                     <= '0;
`endif
    end else begin
      bus.rd_uart     <= capture;
      bus.resync      <= expire;
      bus.right_valid <= 1'b0;
      bus.left_valid  <= 1'b0;
`ifdef UART_RX_PAIR_COMMIT_EN
      if (expire) pending <= '0;
      if (commit) begin
        if (!slot) begin
          pending <= shadow;
        end else begin
          bus.data_second_mouse_right <= pending;
          bus.data_second_mouse_left  <= shadow;
          bus.right_valid             <= 1'b1;
          bus.left_valid              <= 1'b1;
        end
      end
`else
      if (commit) begin
        if (!slot) begin
          bus.data_second_mouse_right <= shadow;
          bus.right_valid             <= 1'b1;
        end else begin
          bus.data_second_mouse_left  <= shadow;
          bus.left_valid              <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_demux.sv
// Bench for uart_rx_demux: FIFO model, directed scenarios, randomized bursts
// checked every cycle against a byte-pairing reference model.
module tb_uart_rx_demux;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_demux_if bus ();

  uart_rx_demux #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rv_cnt = 0;
  int lv_cnt = 0;
  int rs_cnt = 0;
  int rv_cyc = 0;
  int lv_cyc = 0;
  int rs_cyc = 0;
  int rd_q[$];

  logic [7:0] fifo[$];

  // reference model: pairing of popped bytes into right/left
  logic       m_slot = 1'b0;
  logic [7:0] m_right = '0;
  logic [7:0] m_left = '0;
  logic [7:0] m_pending = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.rx_empty = (fifo.size() == 0);
    bus.r_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    drive();
  endtask

  task automatic model_reset();
    fifo.delete();
    m_slot    = 1'b0;
    m_right   = '0;
    m_left    = '0;
    m_pending = '0;
    drive();
  endtask

  task automatic tick();
    logic       popped;
    logic [7:0] b;
    logic       erv;
    logic       elv;
    popped = bus.rd_uart;
    @(posedge clk);
    #1;
    cyc++;
    erv = 1'b0;
    elv = 1'b0;
    if (popped && fifo.size() != 0) begin
      b = fifo.pop_front();
`ifdef UART_RX_PAIR_COMMIT_EN
      if (!m_slot) begin
        m_pending = b;
      end else begin
        m_right = m_pending;
        m_left  = b;
        erv = 1'b1;
        elv = 1'b1;
      end
`else
      if (!m_slot) begin
        m_right = b;
        erv = 1'b1;
      end else begin
        m_left = b;
        elv = 1'b1;
      end
`endif
      m_slot = ~m_slot;
    end
    if (bus.rd_uart) begin
      rd_cnt++;
      rd_q.push_back(cyc);
      check("rd_back_to_back", 32'(popped), 32'd0);
    end
    if (bus.right_valid) begin rv_cnt++; rv_cyc = cyc; end
    if (bus.left_valid)  begin lv_cnt++; lv_cyc = cyc; end
    if (bus.resync)      begin rs_cnt++; rs_cyc = cyc; end
    check("outputs",
      32'({bus.data_second_mouse_right, bus.data_second_mouse_left,
           bus.right_valid, bus.left_valid}),
      32'({m_right, m_left, erv, elv}));
    drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // which: 0 right_valid, 1 left_valid, 2 resync, 3 rd_uart
  task automatic wait_for(input string tag, input int which, input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      unique case (which)
        0:       seen = bus.right_valid;
        1:       seen = bus.left_valid;
        2:       seen = bus.resync;
        default: seen = bus.rd_uart;
      endcase
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      done = (fifo.size() == 0);
    end
    check("drain_done", 32'(done), 32'd1);
    ticks(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    ticks(2);
    check("reset_state",
      32'({bus.rd_uart, bus.resync, bus.right_valid, bus.left_valid,
           bus.data_second_mouse_right, bus.data_second_mouse_left}),
      32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    int p;
    int rd0;
    int rv0;
    int lv0;
    int rs0;
    int n;
    logic was_slot;
    logic long_gap;

    bus.rx_empty = 1'b1;
    bus.r_data   = 8'h00;
    #1;
    do_reset();

`ifndef UART_RX_PAIR_COMMIT_EN
    // two bytes: latency and alternation
    c0 = cyc; rd0 = rd_cnt;
    push(8'h12); push(8'h34);
    wait_for("t1_left_wait", 1, 20);
    check("t1_right_lat", 32'(rv_cyc - c0), 32'd2);
    check("t1_left_lat", 32'(lv_cyc - rv_cyc), 32'd3);
    ticks(4);
    check("t1_pops", 32'(rd_cnt - rd0), 32'd2);

    // six back-to-back bytes: 3-cycle pop period
    rd_q.delete(); rv0 = rv_cnt; lv0 = lv_cnt;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    drain();
    check("t2_pops", 32'(rd_q.size()), 32'd6);
    for (int i = 1; i < rd_q.size(); i++)
      check("t2_period", 32'(rd_q[i] - rd_q[i-1]), 32'd3);
    check("t2_right", 32'(bus.data_second_mouse_right), 32'hA4);
    check("t2_left", 32'(bus.data_second_mouse_left), 32'hA5);
    check("t2_rv_cnt", 32'(rv_cnt - lv0 - (rv0 - lv0)), 32'd3);
    check("t2_lv_cnt", 32'(lv_cnt - lv0), 32'd3);

    // half pair then timeout
    do_reset();
    rs0 = rs_cnt;
    push(8'h55);
    wait_for("t3_right_wait", 0, 20);
    p = rv_cyc;
    wait_for("t3_resync_wait", 2, 40);
    check("t3_resync_time", 32'(rs_cyc - p), 32'(1 + TO));
    check("t3_resync_cnt", 32'(rs_cnt - rs0), 32'd1);
    m_slot = 1'b0;
    push(8'h66);
    wait_for("t3b_right_wait", 0, 20);
    check("t3b_right", 32'(bus.data_second_mouse_right), 32'h66);
    check("t3b_left", 32'(bus.data_second_mouse_left), 32'h00);

    // byte arrives on the expiry cycle: capture wins
    p = rv_cyc;
    while (cyc < p + TO) tick();
    rs0 = rs_cnt;
    push(8'h77);
    ticks(25);
    check("t4_no_resync", 32'(rs_cnt - rs0), 32'd0);
    check("t4_left", 32'(bus.data_second_mouse_left), 32'h77);
    check("t4_left_time", 32'(lv_cyc - p), 32'(TO + 2));

    // reset while in POP drops the captured byte
    push(8'h88);
    drain();
    rv0 = rv_cnt; lv0 = lv_cnt;
    push(8'h99);
    wait_for("t5_pop_wait", 3, 10);
    rst = 1'b1;
    model_reset();
    #1;
    check("t5_async_clear",
      32'({bus.rd_uart, bus.resync, bus.right_valid, bus.left_valid,
           bus.data_second_mouse_right, bus.data_second_mouse_left}),
      32'd0);
    ticks(2);
    check("t5_no_strobe", 32'((rv_cnt - rv0) + (lv_cnt - lv0)), 32'd0);
    rst = 1'b0;
    push(8'hAB);
    wait_for("t5_right_wait", 0, 20);
    check("t5_right", 32'(bus.data_second_mouse_right), 32'hAB);
    check("t5_left", 32'(bus.data_second_mouse_left), 32'h00);
    drain();
    m_slot = 1'b1;
`else
    // atomic pair commit
    push(8'h01); push(8'h02);
    wait_for("p1_pair_wait", 1, 30);
    check("p1_same_cycle", 32'(rv_cyc), 32'(lv_cyc));
    check("p1_right", 32'(bus.data_second_mouse_right), 32'h01);
    check("p1_left", 32'(bus.data_second_mouse_left), 32'h02);
    check("p1_rv_cnt", 32'(rv_cnt), 32'd1);
    rs0 = rs_cnt;
    push(8'h03);
    drain();
    ticks(30);
    check("p2_resync", 32'(rs_cnt - rs0), 32'd1);
    m_slot = 1'b0;
    check("p2_right", 32'(bus.data_second_mouse_right), 32'h01);
    check("p2_left", 32'(bus.data_second_mouse_left), 32'h02);
`endif

    // randomized bursts with short or long idle gaps
    drain();
    ticks(30);
    m_slot = 1'b0;
    for (int it = 0; it < 40; it++) begin
      rs0 = rs_cnt;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) push(8'($urandom_range(0, 255)));
      drain();
      was_slot = m_slot;
      long_gap = ($urandom_range(0, 2) == 0);
      if (long_gap) ticks(30);
      else          ticks($urandom_range(0, 3));
      check("rand_resync", 32'(rs_cnt - rs0), 32'(long_gap && was_slot));
      if (long_gap) m_slot = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
